// File: rtl/uart_host_ctrl_pkg.sv
// Shared types and constants for the UART host controller.
//   state_t   : controller FSM states
//   byte_t    : 8-bit data byte
//   ERR_*     : bit positions inside the 3-bit sticky error vector
package uart_host_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_HOLDOFF = 2'd2,
    ST_READ    = 2'd3
  } state_t;

  typedef logic [7:0] byte_t;

  localparam int ERR_PAR = 0;
  localparam int ERR_FRM = 1;
  localparam int ERR_OVF = 2;

endpackage

// File: rtl/uart_host_ctrl_if.sv
// Bundle of every non-clock signal of the UART host controller.
//   req0_*/req1_*   : two TX requester streams (valid/data in, ready out)
//   rx_*            : received-byte stream to the consumer (valid/data out, ready in)
//   uart_*          : parallel bus and status flags of the UART core
//   err_*, ovf_count, last_src : status/diagnostic outputs
// Modport master is the controller side; slave is the surrounding system.
interface uart_host_ctrl_if;
  import uart_host_ctrl_pkg::*;

  logic  req0_valid;
  byte_t req0_data;
  logic  req0_ready;
  logic  req1_valid;
  byte_t req1_data;
  logic  req1_ready;

  logic  rx_valid;
  byte_t rx_data;
  logic  rx_ready;

  logic  uart_csn;
  logic  uart_wen;
  logic  uart_oen;
  byte_t uart_data_in;
  byte_t uart_data_out;
  logic  uart_txrdy;
  logic  uart_rxrdy;
  logic  uart_parity_err;
  logic  uart_framing_err;
  logic  uart_overflow;

  logic [2:0] err_sticky;
  logic       err_clr;
  byte_t      ovf_count;
  logic       last_src;

  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data, rx_ready,
           uart_data_out, uart_txrdy, uart_rxrdy,
           uart_parity_err, uart_framing_err, uart_overflow, err_clr,
    output req0_ready, req1_ready, rx_valid, rx_data,
           uart_csn, uart_wen, uart_oen, uart_data_in,
           err_sticky, ovf_count, last_src
  );

  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data, rx_ready,
           uart_data_out, uart_txrdy, uart_rxrdy,
           uart_parity_err, uart_framing_err, uart_overflow, err_clr,
    input  req0_ready, req1_ready, rx_valid, rx_data,
           uart_csn, uart_wen, uart_oen, uart_data_in,
           err_sticky, ovf_count, last_src
  );

endinterface

// File: rtl/uart_rr_arb2.sv
// Two-input round-robin arbiter with a last-grant register.
//   clk, rst   : clock, asynchronous active-high reset
//   i_req      : request vector {req1, req0}
//   i_take     : the current grant is consumed this cycle (updates last grant)
//   o_gnt      : one-hot grant (zero when no request)
//   o_gnt_idx  : index of the granted requester
//   o_last     : index of the most recently consumed grant (resets to 1)
module uart_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic [1:0] o_gnt,
  output logic       o_gnt_idx,
  output logic       o_last
);

  logic r_last;

  // On contention favour the requester that did not win last time;
  // a sole requester is always granted.
  always_comb begin
    o_gnt_idx = (i_req == 2'b11) ? ~r_last : i_req[1];
    o_gnt     = (i_req == 2'b00) ? 2'b00 : (o_gnt_idx ? 2'b10 : 2'b01);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_last <= 1'b1;
    else if (i_take) r_last <= o_gnt_idx;
  end

  assign o_last = r_last;

endmodule

// File: rtl/uart_host_ctrl.sv
// Host-side controller for a parallel-bus UART core.
//   CLK, RESET : clock, asynchronous active-high reset
//   bus        : uart_host_ctrl_if.master -- two TX requester streams,
//                RX consumer stream, UART strobes/data/flags, sticky error
//                flags, overflow event counter and last granted requester.
// Arbitrates the two requesters onto single-cycle UART writes followed by a
// TXRDY holdoff window, and moves received bytes into a 1-entry buffer with
// multi-cycle reads. Reads take priority over writes when idle.
module uart_host_ctrl
  import uart_host_ctrl_pkg::*;
#(
  parameter int RD_CYCLES  = 2,
  parameter int TX_HOLDOFF = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  uart_host_ctrl_if.master bus
);

  state_t     r_state, w_next;
  logic [2:0] r_cnt, w_cnt_next;
  byte_t      r_data_in;
  logic       r_rx_full;
  byte_t      r_rx_data;
  logic [2:0] r_err;
  logic [2:0] w_err_set;
  byte_t      r_ovf_cnt;
  logic       r_ovf_d;

  logic       w_rd_sel, w_wr_sel, w_rd_last;
  logic [1:0] w_req, w_gnt;
  logic       w_gnt_idx, w_last;

  assign w_req = {bus.req1_valid, bus.req0_valid};

  uart_rr_arb2 u_arb (
    .clk       (CLK),
    .rst       (RESET),
    .i_req     (w_req),
    .i_take    (w_wr_sel),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_last    (w_last)
  );

  // One shared down-counter: holdoff length in HOLDOFF, remaining strobe
  // cycles in READ. It is always zero in IDLE.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_rd_sel   = 1'b0;
    w_wr_sel   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.uart_rxrdy && !r_rx_full) begin
          w_rd_sel   = 1'b1;
          w_next     = ST_READ;
          w_cnt_next = 3'(RD_CYCLES);
        end else if (bus.uart_txrdy && r_cnt == 3'd0 && |w_req) begin
          w_wr_sel = 1'b1;
          w_next   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        w_next     = ST_HOLDOFF;
        w_cnt_next = 3'(TX_HOLDOFF);
      end
      ST_HOLDOFF, ST_READ: begin
        if (r_cnt != 3'd0) w_cnt_next = r_cnt - 3'd1;
        if (r_cnt <= 3'd1) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_rd_last = (r_state == ST_READ) && (r_cnt == 3'd1);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 3'd0;
      r_data_in <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_wr_sel) r_data_in <= w_gnt_idx ? bus.req1_data : bus.req0_data;
    end
  end

  // A new read only starts with the buffer empty, so fill and drain never
  // coincide; fill is written last anyway.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_rx_full <= 1'b0;
      r_rx_data <= '0;
    end else begin
      if (r_rx_full && bus.rx_ready) r_rx_full <= 1'b0;
      if (w_rd_last) begin
        r_rx_full <= 1'b1;
        r_rx_data <= bus.uart_data_out;
      end
    end
  end

  always_comb begin
    w_err_set          = '0;
    w_err_set[ERR_PAR] = bus.uart_parity_err;
    w_err_set[ERR_FRM] = bus.uart_framing_err;
    w_err_set[ERR_OVF] = bus.uart_overflow;
  end

  // Set wins over clear: the clear is applied first, then new flags OR in.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_err     <= '0;
      r_ovf_cnt <= '0;
      r_ovf_d   <= 1'b0;
    end else begin
      r_err   <= (bus.err_clr ? 3'b000 : r_err) | w_err_set;
      r_ovf_d <= bus.uart_overflow;
      if (bus.uart_overflow && !r_ovf_d && r_ovf_cnt != 8'hFF)
        r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
  end

  // Strobes decode straight from the state register, so an asynchronous
  // reset releases them immediately.
  assign bus.uart_csn     = !(r_state == ST_WRITE || r_state == ST_READ);
  assign bus.uart_wen     = (r_state != ST_WRITE);
  assign bus.uart_oen     = (r_state != ST_READ);
  assign bus.uart_data_in = r_data_in;

  // Ready is combinational in the selecting IDLE cycle; the byte moves then.
  assign bus.req0_ready = w_wr_sel && w_gnt[0] && !RESET;
  assign bus.req1_ready = w_wr_sel && w_gnt[1] && !RESET;

  assign bus.rx_valid   = r_rx_full;
  assign bus.rx_data    = r_rx_data;
  assign bus.err_sticky = r_err;
  assign bus.ovf_count  = r_ovf_cnt;
  assign bus.last_src   = w_last;

endmodule
